// File: rtl/trade_limiter.sv
// Multi-channel trade limiter: per-channel lifetime and per-window rate limits with independent
// halt FSMs, plus a saturating global total of accepted trades.
module trade_limiter #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    parameter int WIN_CYCLES = 1000,
    parameter int WIN_CNT_W  = 4,
    parameter int TOT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         match,
    input  logic [NUM_CH-1:0]         clear_halt,
    input  logic [CNT_W-1:0]          max_trades,
    input  logic [WIN_CNT_W-1:0]      max_per_win,
    output logic [NUM_CH-1:0]         trade_accept,
    output logic [NUM_CH*CNT_W-1:0]   trade_count,
    output logic [NUM_CH-1:0]         halt,
    output logic [NUM_CH-1:0]         throttled,
    output logic [TOT_W-1:0]          total_count,
    output logic                      any_halt
);

    localparam int TMR_W = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
    localparam int POP_W = $clog2(NUM_CH + 1);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t               r_state      [NUM_CH];
    state_t               w_state_next [NUM_CH];
    logic [CNT_W-1:0]     r_count      [NUM_CH];
    logic [CNT_W-1:0]     w_count_next [NUM_CH];
    logic [WIN_CNT_W-1:0] r_win_cnt    [NUM_CH];
    logic [WIN_CNT_W-1:0] w_win_next   [NUM_CH];
    logic [NUM_CH-1:0]    r_throttled;
    logic [NUM_CH-1:0]    w_throttled_next;
    logic [NUM_CH-1:0]    w_accept;
    logic [NUM_CH-1:0]    w_halt_next;
    logic [TMR_W-1:0]     r_timer;
    logic                 w_wrap;
    logic [POP_W-1:0]     w_pop;
    logic [TOT_W:0]       w_total_sum;
    logic [TOT_W-1:0]     r_total;
    logic [TOT_W-1:0]     w_total_next;
    logic                 r_any_halt;

    assign w_wrap = (r_timer == TMR_W'(WIN_CYCLES - 1));

    // Per-channel next state; clear_halt overrides everything on its channel, including a match.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_accept[i] = match[i] & enable & ~reset & (r_state[i] == ST_RUN) & ~r_throttled[i]
                        & (r_count[i] < max_trades) & ~clear_halt[i];
            w_count_next[i] = r_count[i];
            w_win_next[i]   = r_win_cnt[i];
            w_state_next[i] = r_state[i];
            if (clear_halt[i]) begin
                w_count_next[i] = '0;
                w_win_next[i]   = '0;
                w_state_next[i] = ST_RUN;
            end else begin
                if (w_accept[i])
                    w_count_next[i] = r_count[i] + CNT_W'(1);
                if (w_wrap)
                    w_win_next[i] = w_accept[i] ? WIN_CNT_W'(1) : '0;
                else if (w_accept[i] && (r_win_cnt[i] != '1))
                    w_win_next[i] = r_win_cnt[i] + WIN_CNT_W'(1);
                // Uses the post-accept count so the halting trade and HALT land on one edge.
                if ((r_state[i] == ST_RUN) && (w_count_next[i] >= max_trades))
                    w_state_next[i] = ST_HALT;
            end
            w_throttled_next[i] = ~clear_halt[i]
                & (((max_per_win != '0) && (w_win_next[i] >= max_per_win))
                   | (r_throttled[i] & ~w_wrap));
            w_halt_next[i] = (w_state_next[i] == ST_HALT);
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_pop = w_pop + POP_W'(w_accept[i]);
        w_total_sum  = {1'b0, r_total} + (TOT_W + 1)'(w_pop);
        w_total_next = w_total_sum[TOT_W] ? '1 : w_total_sum[TOT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]   <= ST_RUN;
                r_count[i]   <= '0;
                r_win_cnt[i] <= '0;
            end
            r_throttled <= '0;
            r_timer     <= '0;
            r_total     <= '0;
            r_any_halt  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]   <= w_state_next[i];
                r_count[i]   <= w_count_next[i];
                r_win_cnt[i] <= w_win_next[i];
            end
            r_throttled <= w_throttled_next;
            r_timer     <= w_wrap ? '0 : r_timer + TMR_W'(1);
            r_total     <= w_total_next;
            r_any_halt  <= |w_halt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
            assign trade_count[gi*CNT_W +: CNT_W] = r_count[gi];
            assign halt[gi]                       = (r_state[gi] == ST_HALT);
        end
    endgenerate

    assign trade_accept = w_accept;
    assign throttled    = r_throttled;
    assign total_count  = r_total;
    assign any_halt     = r_any_halt;

endmodule

// File: tb/tb_trade_limiter.sv
// Directed bench for trade_limiter: lifetime halt, clear, rate window, all-channel bursts,
// zero limit and asynchronous reset, each with hand-computed expectations.
module tb_trade_limiter;
    localparam int NUM_CH = 4, CNT_W = 8, WIN_CYCLES = 10, WIN_CNT_W = 4, TOT_W = 16;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    enable = 1'b0;
    logic [NUM_CH-1:0]       match = '0;
    logic [NUM_CH-1:0]       clear_halt = '0;
    logic [CNT_W-1:0]        max_trades = 8'd200;
    logic [WIN_CNT_W-1:0]    max_per_win = '0;
    logic [NUM_CH-1:0]       trade_accept;
    logic [NUM_CH*CNT_W-1:0] trade_count;
    logic [NUM_CH-1:0]       halt;
    logic [NUM_CH-1:0]       throttled;
    logic [TOT_W-1:0]        total_count;
    logic                    any_halt;

    int checks = 0;
    int failures = 0;

    trade_limiter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_CYCLES(WIN_CYCLES),
                    .WIN_CNT_W(WIN_CNT_W), .TOT_W(TOT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .match(match), .clear_halt(clear_halt),
        .max_trades(max_trades), .max_per_win(max_per_win), .trade_accept(trade_accept),
        .trade_count(trade_count), .halt(halt), .throttled(throttled),
        .total_count(total_count), .any_halt(any_halt)
    );

    always #5 clk = ~clk;

    // Leaves the bench on a falling edge with the window timer at 0.
    task automatic do_reset(input logic [CNT_W-1:0] mt, input logic [WIN_CNT_W-1:0] mpw);
        @(negedge clk);
        reset = 1'b1; enable = 1'b1; match = '0; clear_halt = '0;
        max_trades = mt; max_per_win = mpw;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({trade_count, halt, throttled, total_count, any_halt} !== '0) begin
            failures++;
            $display("FAIL reset_state: count=%h halt=%b thr=%b total=%0d any=%b required all 0",
                     trade_count, halt, throttled, total_count, any_halt);
        end
        do_reset(8'd200, 4'd0);
    endtask

    task automatic test_lifetime;
        logic [CNT_W-1:0] c;
        do_reset(8'd3, 4'd0);
        for (int k = 1; k <= 4; k++) begin
            match = 4'b0001;
            #1;
            checks++;
            if (trade_accept !== ((k <= 3) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL lifetime_accept k=%0d: got %b", k, trade_accept);
            end
            @(posedge clk); #1;
            c = trade_count[CNT_W-1:0];
            $display("txn lifetime k=%0d count0=%0d halt=%b total=%0d", k, c, halt, total_count);
            checks++;
            if (c !== CNT_W'((k <= 3) ? k : 3)) begin
                failures++;
                $display("FAIL lifetime_count k=%0d: got %0d required %0d", k, c, (k <= 3) ? k : 3);
            end
            checks++;
            if (halt !== ((k >= 3) ? 4'b0001 : 4'b0000) || any_halt !== (k >= 3)) begin
                failures++;
                $display("FAIL lifetime_halt k=%0d: halt=%b any=%b", k, halt, any_halt);
            end
            @(negedge clk);
        end
        match = '0;
    endtask

    task automatic test_clear_halt;
        match = 4'b0001; clear_halt = 4'b0001;
        #1;
        checks++;
        if (trade_accept !== 4'b0000) begin
            failures++;
            $display("FAIL clear_accept: got %b required 0000", trade_accept);
        end
        @(posedge clk); #1;
        $display("txn clear count0=%0d halt=%b total=%0d", trade_count[CNT_W-1:0], halt, total_count);
        checks++;
        if (trade_count[CNT_W-1:0] !== 8'd0 || halt !== 4'b0000 || total_count !== 16'd3) begin
            failures++;
            $display("FAIL clear_state: count0=%0d halt=%b total=%0d required 0 0000 3",
                     trade_count[CNT_W-1:0], halt, total_count);
        end
        @(negedge clk);
        clear_halt = '0;
        #1;
        checks++;
        if (trade_accept !== 4'b0001) begin
            failures++;
            $display("FAIL clear_resume_accept: got %b required 0001", trade_accept);
        end
        @(posedge clk); #1;
        checks++;
        if (trade_count[CNT_W-1:0] !== 8'd1 || halt !== 4'b0000) begin
            failures++;
            $display("FAIL clear_resume: count0=%0d halt=%b required 1 0000",
                     trade_count[CNT_W-1:0], halt);
        end
        @(negedge clk);
        match = '0;
    endtask

    task automatic test_rate;
        int exp_cnt;
        logic exp_acc, exp_thr;
        do_reset(8'd200, 4'd2);
        exp_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            match = 4'b0010;
            exp_acc = (k == 1) || (k == 2) || (k == 11) || (k == 12);
            exp_thr = ((k >= 2) && (k <= 9)) || (k >= 12);
            if (exp_acc) exp_cnt++;
            #1;
            checks++;
            if (trade_accept !== {2'b00, exp_acc, 1'b0}) begin
                failures++;
                $display("FAIL rate_accept k=%0d: got %b required %b", k, trade_accept,
                         {2'b00, exp_acc, 1'b0});
            end
            @(posedge clk); #1;
            $display("txn rate k=%0d count1=%0d thr=%b", k, trade_count[2*CNT_W-1:CNT_W], throttled);
            checks++;
            if (trade_count[2*CNT_W-1:CNT_W] !== CNT_W'(exp_cnt) ||
                throttled !== {2'b00, exp_thr, 1'b0} || halt !== 4'b0000) begin
                failures++;
                $display("FAIL rate_state k=%0d: count1=%0d thr=%b halt=%b required %0d %b 0000",
                         k, trade_count[2*CNT_W-1:CNT_W], throttled, halt, exp_cnt,
                         {2'b00, exp_thr, 1'b0});
            end
            @(negedge clk);
        end
        match = '0;
    endtask

    task automatic test_all_channels;
        do_reset(8'd200, 4'd0);
        for (int k = 1; k <= 6; k++) begin
            match = 4'b1111;
            enable = (k <= 5);
            #1;
            checks++;
            if (trade_accept !== ((k <= 5) ? 4'b1111 : 4'b0000)) begin
                failures++;
                $display("FAIL all_accept k=%0d: got %b", k, trade_accept);
            end
            @(posedge clk); #1;
            $display("txn all k=%0d counts=%h total=%0d", k, trade_count, total_count);
            for (int i = 0; i < NUM_CH; i++) begin
                checks++;
                if (trade_count[i*CNT_W +: CNT_W] !== CNT_W'((k <= 5) ? k : 5)) begin
                    failures++;
                    $display("FAIL all_count ch=%0d k=%0d: got %0d", i, k, trade_count[i*CNT_W +: CNT_W]);
                end
            end
            checks++;
            if (total_count !== TOT_W'(4 * ((k <= 5) ? k : 5))) begin
                failures++;
                $display("FAIL all_total k=%0d: got %0d", k, total_count);
            end
            @(negedge clk);
        end
        match = '0; enable = 1'b1;
    endtask

    task automatic test_zero_limit;
        do_reset(8'd0, 4'd0);
        match = 4'b1111;
        #1;
        checks++;
        if (trade_accept !== 4'b0000) begin
            failures++;
            $display("FAIL zero_accept: got %b required 0000", trade_accept);
        end
        @(posedge clk); #1;
        $display("txn zero halt=%b any=%b total=%0d", halt, any_halt, total_count);
        checks++;
        if (halt !== 4'b1111 || any_halt !== 1'b1 || total_count !== 16'd0) begin
            failures++;
            $display("FAIL zero_halt: halt=%b any=%b total=%0d required 1111 1 0", halt, any_halt, total_count);
        end
        @(negedge clk);
        clear_halt = 4'b0001;
        @(posedge clk); #1;
        checks++;
        if (halt !== 4'b1110) begin
            failures++;
            $display("FAIL zero_clear: halt=%b required 1110", halt);
        end
        @(negedge clk);
        clear_halt = '0;
        #1;
        checks++;
        if (trade_accept !== 4'b0000) begin
            failures++;
            $display("FAIL zero_clear_accept: got %b required 0000", trade_accept);
        end
        @(posedge clk); #1;
        checks++;
        if (halt !== 4'b1111 || trade_count !== '0) begin
            failures++;
            $display("FAIL zero_rehalt: halt=%b counts=%h required 1111 0", halt, trade_count);
        end
        @(negedge clk);
        match = '0;
    endtask

    task automatic test_async_reset;
        do_reset(8'd200, 4'd0);
        match = 4'b1111;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        $display("txn async_reset counts=%h total=%0d", trade_count, total_count);
        checks++;
        if ({trade_accept, trade_count, halt, throttled, total_count, any_halt} !== '0) begin
            failures++;
            $display("FAIL async_reset: acc=%b counts=%h halt=%b total=%0d required all 0",
                     trade_accept, trade_count, halt, total_count);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (trade_count !== 32'h01010101 || total_count !== 16'd4) begin
            failures++;
            $display("FAIL async_restart: counts=%h total=%0d required 01010101 4", trade_count, total_count);
        end
        @(negedge clk);
        match = '0;
    endtask

    initial begin
        test_reset;
        test_lifetime;
        test_clear_halt;
        test_rate;
        test_all_channels;
        test_zero_limit;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
